// File: rtl/fmul_pkg.sv
// Shared constants for the multi-cycle FP multiplier: state codes and default latencies.
// Used by the sequencer, the datapath top and the bench.
package fmul_pkg;

  localparam int MULT_LAT_DEF = 2;
  localparam int CW_DEF       = 4;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_LOAD_OP  = 4'd1;
  localparam logic [3:0] ST_EXP_ADD  = 4'd2;
  localparam logic [3:0] ST_SGF_MULT = 4'd3;
  localparam logic [3:0] ST_NORM     = 4'd4;
  localparam logic [3:0] ST_ROUND    = 4'd5;
  localparam logic [3:0] ST_RENORM   = 4'd6;
  localparam logic [3:0] ST_LOAD_OUT = 4'd7;
  localparam logic [3:0] ST_DONE     = 4'd8;

  typedef enum logic [3:0] {
    IDLE     = ST_IDLE,
    LOAD_OP  = ST_LOAD_OP,
    EXP_ADD  = ST_EXP_ADD,
    SGF_MULT = ST_SGF_MULT,
    NORM     = ST_NORM,
    ROUND    = ST_ROUND,
    RENORM   = ST_RENORM,
    LOAD_OUT = ST_LOAD_OUT,
    DONE     = ST_DONE
  } fmul_state_e;

endpackage

// File: rtl/fmul_lat_counter.sv
// Loadable down-counter with zero flag; load has priority over decrement,
// and the count saturates at zero.
module fmul_lat_counter
  import fmul_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/fmul_ctrl_seq.sv
// Sequencer for the FP multiplier pipeline registers: one-hot Moore load strobes.
// Optional macro FMUL_SEQ_B2B_EN lets ack+start in DONE chain straight into the next op.
module fmul_ctrl_seq
  import fmul_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic beg_op,
  input  logic ack_op,
  input  logic zero_flag,
  input  logic round_carry,
  input  logic ovf_flag,
  input  logic unf_flag,
  output logic load_op,
  output logic load_exp,
  output logic load_sgf,
  output logic load_norm,
  output logic load_rnd,
  output logic load_out,
  output logic sel_zero,
  output logic busy,
  output logic ready,
  output logic exc_ovf,
  output logic exc_unf
);

  fmul_state_e state_q, state_d;
  logic sel_zero_q, sel_zero_d;
  logic exc_ovf_q, exc_ovf_d;
  logic exc_unf_q, exc_unf_d;
  logic cnt_zero;

  // Counter is armed in EXP_ADD so SGF_MULT dwells exactly MULT_LAT cycles.
  fmul_lat_counter #(.CW(CW)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == EXP_ADD),
    .load_val (CW'(MULT_LAT - 1)),
    .dec      (state_q == SGF_MULT),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    sel_zero_d = sel_zero_q;
    exc_ovf_d  = exc_ovf_q;
    exc_unf_d  = exc_unf_q;
    unique case (state_q)
      IDLE: begin
        if (beg_op) state_d = LOAD_OP;
      end
      LOAD_OP: begin
        sel_zero_d = 1'b0;
        exc_ovf_d  = 1'b0;
        exc_unf_d  = 1'b0;
        state_d    = EXP_ADD;
      end
      EXP_ADD: begin
        // A zero operand skips the arithmetic and never raises exceptions.
        if (zero_flag) begin
          sel_zero_d = 1'b1;
          state_d    = LOAD_OUT;
        end else begin
          state_d = SGF_MULT;
        end
      end
      SGF_MULT: begin
        if (cnt_zero) state_d = NORM;
      end
      NORM: begin
        state_d = ROUND;
      end
      ROUND: begin
        exc_ovf_d = exc_ovf_q | ovf_flag;
        exc_unf_d = exc_unf_q | unf_flag;
        state_d   = round_carry ? RENORM : LOAD_OUT;
      end
      RENORM: begin
        exc_ovf_d = exc_ovf_q | ovf_flag;
        exc_unf_d = exc_unf_q | unf_flag;
        state_d   = LOAD_OUT;
      end
      LOAD_OUT: begin
        state_d = DONE;
      end
      DONE: begin
        if (ack_op) begin
`ifdef FMUL_SEQ_B2B_EN
          state_d = beg_op ? LOAD_OP : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_zero_q <= 1'b0;
      exc_ovf_q  <= 1'b0;
      exc_unf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_zero_q <= sel_zero_d;
      exc_ovf_q  <= exc_ovf_d;
      exc_unf_q  <= exc_unf_d;
    end
  end

  always_comb begin
    load_op   = (state_q == LOAD_OP);
    load_exp  = (state_q == EXP_ADD);
    load_sgf  = (state_q == SGF_MULT) && cnt_zero;
    load_norm = (state_q == NORM) || (state_q == RENORM);
    load_rnd  = (state_q == ROUND);
    load_out  = (state_q == LOAD_OUT);
    busy      = (state_q != IDLE);
    ready     = (state_q == DONE);
  end

  assign sel_zero = sel_zero_q;
  assign exc_ovf  = exc_ovf_q;
  assign exc_unf  = exc_unf_q;

endmodule

// File: tb/tb_fmul_ctrl_seq.sv
// Scoreboard bench for fmul_ctrl_seq: stimulus pushes the expected op profile,
// a negedge monitor measures strobes/latency/flags and compares on each ready.
module tb_fmul_ctrl_seq;
  import fmul_pkg::*;

  localparam int ML = MULT_LAT_DEF;
`ifdef FMUL_SEQ_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  localparam int GAP_EXP = B2B ? 1 : 2;

  typedef struct {
    int lat;
    int sgf_off;
    int n_sgf;
    int n_norm;
    int n_rnd;
    int out_off;
    int eovf;
    int eunf;
    int szero;
    int gap;
  } exp_t;

  exp_t sb_q[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic beg_op = 1'b0, ack_op = 1'b0, zero_flag = 1'b0, round_carry = 1'b0;
  logic ovf_flag = 1'b0, unf_flag = 1'b0;
  logic load_op, load_exp, load_sgf, load_norm, load_rnd, load_out;
  logic sel_zero, busy, ready, exc_ovf, exc_unf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fmul_ctrl_seq #(.MULT_LAT(ML), .CW(CW_DEF)) dut (
    .clk(clk), .rst(rst), .beg_op(beg_op), .ack_op(ack_op),
    .zero_flag(zero_flag), .round_carry(round_carry),
    .ovf_flag(ovf_flag), .unf_flag(unf_flag),
    .load_op(load_op), .load_exp(load_exp), .load_sgf(load_sgf),
    .load_norm(load_norm), .load_rnd(load_rnd), .load_out(load_out),
    .sel_zero(sel_zero), .busy(busy), .ready(ready),
    .exc_ovf(exc_ovf), .exc_unf(exc_unf)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic int outs_vec();
    return int'({load_op, load_exp, load_sgf, load_norm, load_rnd, load_out,
                 sel_zero, busy, ready, exc_ovf, exc_unf});
  endfunction

  // Monitor: measures each op from its load_op cycle and pops on ready rise.
  initial begin
    int m_start = 0, m_sgf = 0, m_norm = 0, m_rnd = 0;
    int m_sgf_off = -1, m_out_off = -1, m_gap = 0, last_ack = -100;
    logic ready_prev = 1'b0, acked_prev = 1'b0, beg_prev = 1'b0;
    logic [5:0] strobes;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ready_prev = 1'b0;
        acked_prev = 1'b0;
        last_ack   = -100;
      end else begin
        strobes = {load_op, load_exp, load_sgf, load_norm, load_rnd, load_out};
        chk("onehot", int'($countones(strobes) > 1), 0);
        if (acked_prev) chk("busy_after_ack", int'(busy), int'(B2B && beg_prev));
        if (load_op) begin
          m_start = cyc; m_sgf = 0; m_norm = 0; m_rnd = 0;
          m_sgf_off = -1; m_out_off = -1; m_gap = cyc - last_ack;
        end
        if (load_exp) chk("clr_at_loadop", int'({exc_ovf, exc_unf, sel_zero}), 0);
        if (load_sgf) begin m_sgf++; m_sgf_off = cyc - m_start; end
        if (load_norm) m_norm++;
        if (load_rnd) m_rnd++;
        if (load_out) m_out_off = cyc - m_start;
        if (ready && !ready_prev) begin
          chk("sb_nonempty", int'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("latency", cyc - m_start + 1, e.lat);
            chk("n_sgf", m_sgf, e.n_sgf);
            chk("n_norm", m_norm, e.n_norm);
            chk("n_rnd", m_rnd, e.n_rnd);
            chk("out_off", m_out_off, e.out_off);
            chk("exc_ovf", int'(exc_ovf), e.eovf);
            chk("exc_unf", int'(exc_unf), e.eunf);
            chk("sel_zero", int'(sel_zero), e.szero);
            chk("busy_in_done", int'(busy), 1);
            if (e.sgf_off >= 0) chk("sgf_off", m_sgf_off, e.sgf_off);
            if (e.gap >= 0) chk("start_gap", m_gap, e.gap);
          end
        end
        acked_prev = ready && ack_op;
        beg_prev   = beg_op;
        if (acked_prev) last_ack = cyc;
        ready_prev = ready;
      end
    end
  end

  // One operation; inputs change at posedge+1 so they are stable at the next edge.
  task automatic run_op(input bit zf, input bit rc, input bit o_r, input bit u_r,
                        input bit o_n, input bit u_n, input bit allf, input bit early,
                        input bit hold, input int ack_dly, input int gap);
    exp_t e;
    bit started = 1'b0, seen_rnd = 1'b0, renorm, ack_pending = 1'b0, done = 1'b0;
    int rdy_cnt = 0;
    e.lat     = zf ? 4 : (rc ? ML + 7 : ML + 6);
    e.sgf_off = zf ? -1 : ML + 1;
    e.n_sgf   = zf ? 0 : 1;
    e.n_norm  = zf ? 0 : (rc ? 2 : 1);
    e.n_rnd   = zf ? 0 : 1;
    e.out_off = zf ? 2 : (rc ? ML + 5 : ML + 4);
    e.eovf    = int'(!zf && (o_r || allf || (rc && o_n)));
    e.eunf    = int'(!zf && (u_r || allf || (rc && u_n)));
    e.szero   = int'(zf);
    e.gap     = gap;
    sb_q.push_back(e);
    beg_op = 1'b1;
    zero_flag = zf;
    round_carry = rc;
    ack_op = early;
    ovf_flag = allf;
    unf_flag = allf;
    if (load_op) begin
      started = 1'b1;
      if (!hold) beg_op = 1'b0;
    end
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      if (load_op) started = 1'b1;
      if (started && !hold) beg_op = 1'b0;
      renorm = load_norm && seen_rnd;
      if (load_rnd) seen_rnd = 1'b1;
      ovf_flag = allf | (o_r & load_rnd) | (o_n & renorm);
      unf_flag = allf | (u_r & load_rnd) | (u_n & renorm);
      if (ack_pending) begin
        ack_op = 1'b0;
        ovf_flag = 1'b0;
        unf_flag = 1'b0;
        zero_flag = 1'b0;
        round_carry = 1'b0;
        done = 1'b1;
      end else if (ready) begin
        rdy_cnt++;
        if (early || rdy_cnt > ack_dly) begin
          ack_op = 1'b1;
          ack_pending = 1'b1;
        end
      end
    end
    chk("op_completed", int'(done), 1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", outs_vec(), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", outs_vec(), 0);

    //     zf rc o_r u_r o_n u_n allf early hold dly gap
    run_op(0, 0, 0,  0,  0,  0,  0,   0,    0,   2,  -1);   // normal
    run_op(1, 0, 0,  0,  0,  0,  1,   0,    0,   1,  -1);   // zero bypass, flags ignored
    run_op(0, 1, 0,  0,  0,  0,  0,   0,    0,   0,  -1);   // renorm
    run_op(0, 1, 0,  0,  1,  0,  0,   0,    0,   1,  -1);   // ovf only in RENORM
    run_op(0, 0, 0,  1,  0,  0,  0,   0,    0,   0,  -1);   // unf in ROUND, ovf cleared
    run_op(0, 0, 0,  0,  0,  0,  0,   1,    0,   0,  -1);   // ack held from start

    // Abort during SGF_MULT.
    beg_op = 1'b1;
    @(posedge clk); #1;
    beg_op = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_before_abort", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_abort", outs_vec(), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_hold", outs_vec(), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, -1);              // clean restart

    // beg_op held across DONE: second op follows the ack.
    run_op(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, -1);
    run_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, GAP_EXP);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 0);
    chk("idle_at_end", int'(busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmul_ctrl_seq.md
Name: fmul_ctrl_seq

Overview:
- Control FSM sequencing the load-enabled pipeline registers of the multi-cycle floating-point multiplier datapath.
- Accepts a start/ack handshake from the FPU top level.
- Issues one-hot load strobes to operand, exponent, significand, normalisation, rounding and output registers.
- Handles zero-operand bypass, post-round renormalisation and overflow/underflow flagging.

Parameters:
- MULT_LAT, 2: cycles the significand multiplier needs; legal range 1..15.
- CW, 4: width of the internal latency counter; must satisfy 2**CW > MULT_LAT.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- beg_op  in  1  start request; sampled only in IDLE
- ack_op  in  1  result consumed; sampled only in DONE
- zero_flag  in  1  an operand is zero (from datapath)
- round_carry  in  1  rounding overflowed the significand
- ovf_flag  in  1  exponent overflow (datapath)
- unf_flag  in  1  exponent underflow (datapath)
- load_op  out  1  load operand registers
- load_exp  out  1  load exponent-sum register
- load_sgf  out  1  load significand-product register
- load_norm  out  1  load normalised significand/exponent
- load_rnd  out  1  load rounded result
- load_out  out  1  load final output register
- sel_zero  out  1  output mux selects signed zero
- busy  out  1  high in every state except IDLE
- ready  out  1  result valid; high only in DONE
- exc_ovf  out  1  sticky overflow of current op
- exc_unf  out  1  sticky underflow of current op

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. Assertion mid-operation aborts immediately; no strobe is produced after rst rises.
- Outputs are Moore, decoded from registered state. At most one load_* is high per cycle.
- States and transitions:
  - IDLE: go to LOAD_OP if beg_op.
  - LOAD_OP: load_op=1. Clears exc_ovf, exc_unf and sel_zero. Go to EXP_ADD.
  - EXP_ADD: load_exp=1. If zero_flag, set sel_zero and go to LOAD_OUT. Otherwise load counter with MULT_LAT-1 and go to SGF_MULT.
  - SGF_MULT: counter decrements each cycle. load_sgf=1 only in the cycle where counter==0, then go to NORM. Total dwell is MULT_LAT cycles.
  - NORM: load_norm=1. Go to ROUND.
  - ROUND: load_rnd=1. Latch ovf_flag/unf_flag into exc_* (OR). Go to RENORM if round_carry, else LOAD_OUT.
  - RENORM: load_norm=1. Latch ovf/unf again (OR). Go to LOAD_OUT.
  - LOAD_OUT: load_out=1. Go to DONE.
  - DONE: ready=1, busy=1. Hold until ack_op, then go to IDLE.
- Latency is counted with the beg_op sampling edge as cycle 0:
  - normal path: ready in cycle MULT_LAT+6 (8 at default);
  - with renorm: MULT_LAT+7;
  - zero bypass: cycle 4.
- beg_op outside IDLE is ignored, not queued. ack_op outside DONE is ignored.
- beg_op and ack_op high together in DONE: ack wins; the start is dropped unless the optional feature is on.
- zero_flag takes priority over ovf/unf; exc_* stay 0 on the bypass path.
- exc_* and sel_zero remain valid through DONE and until the next LOAD_OP.

Optional Feature:
- Macro FMUL_SEQ_B2B_EN.
- Defined: in DONE, ack_op && beg_op moves directly to LOAD_OP, giving back-to-back ops with no IDLE bubble.
- Undefined: DONE always returns to IDLE; the next beg_op is sampled one cycle later at earliest.

Decomposition:
- Shared package fmul_pkg holds:
  - the state encoding localparams (IDLE..DONE, 4-bit binary);
  - the MULT_LAT default;
  - the CW default.
- These are also used by the datapath top and the bench.
- Natural sub-module: fmul_lat_counter, a loadable down-counter with a zero flag, reusable for other multi-cycle FPU units.

Test Plan:
- Normal op: beg_op pulse, zero_flag=0, round_carry=0, ack after 2 cycles -> strobes in order op, exp, sgf (at cycle 4), norm, rnd, out; ready at cycle 8; busy falls the cycle after ack.
- Zero bypass: zero_flag=1 during EXP_ADD -> no load_sgf, load_norm or load_rnd; load_out at cycle 3; sel_zero=1; ready at cycle 4.
- Renorm: round_carry=1 in ROUND -> load_norm pulses twice; ready at cycle 9.
- Exceptions: ovf_flag=1 only during RENORM -> exc_ovf=1 in DONE, exc_unf=0. Next op clears exc_ovf at LOAD_OP.
- Reset mid-op: rst asserted during SGF_MULT -> all outputs 0 the same cycle; a later beg_op restarts cleanly with latency 8.
- Handshake corners:
  - beg_op held high through a whole op with ack in DONE -> second op starts at the first IDLE cycle;
  - with FMUL_SEQ_B2B_EN, the second op starts the cycle after DONE;
  - MULT_LAT=1 build -> ready at cycle 7.
